// File: rtl/sky130_iocfg_seq.sv
// sky130_iocfg_seq
// Power-on sequencer and run-time configuration controller for a bank of
// sky130 GPIO pad buffers. Drives one 16-bit tech_cfg vector per pad: pads
// are held hi-z until the I/O supply settles, then enabled and released.
// Per-pad pull/slew settings are written afterwards over a valid/ready
// handshake. Each write is applied glitch-free by holding only the target
// pad's outputs while its drive settings change.
//
// Every output is a flop. The output flops are loaded from the *next* state
// values, so they change on the same edge as the FSM. There is no
// combinational path from any input to any output.

module sky130_iocfg_seq #(
   parameter int N              = 4,
   parameter int TECH_CFG_WIDTH = 16,
   parameter int ENABLE_DLY     = 16,
   parameter int HOLD_DLY       = 4,
   parameter int PW             = (N > 1) ? $clog2(N) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [PW-1:0]               req_pad,
   input  logic [7:0]                  req_cfg,
   output logic                        cfg_done,
   output logic                        cfg_err,
   output logic                        busy,
   output logic                        pwr_good,
   output logic [N*TECH_CFG_WIDTH-1:0] tech_cfg
);

   // A single down-counter times every timed state. It is sized for the
   // longer of the two delays.
   localparam int MAX_DLY = (ENABLE_DLY > HOLD_DLY) ? ENABLE_DLY : HOLD_DLY;
   localparam int CW      = $clog2(MAX_DLY + 1);

   // The counter is loaded with (delay - 1). The state is left when the
   // counter reads zero, so a state lasts exactly 'delay' cycles.
   localparam logic [CW-1:0] ENA_LOAD  = CW'(ENABLE_DLY - 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_DLY - 1);

   // Pad count, widened by one bit so that it compares against req_pad
   // without truncation.
   localparam logic [PW:0] N_EXT = (PW + 1)'(N);

   // Pad word while in reset: hi-z, held, strong drive mode (DM = 110).
   localparam logic [TECH_CFG_WIDTH-1:0] RESET_WORD = TECH_CFG_WIDTH'(16'hC000);

   typedef enum logic [2:0] {
      S_PWR_WAIT  = 3'd0,
      S_ENABLE    = 3'd1,
      S_IDLE      = 3'd2,
      S_HOLD_PRE  = 3'd3,
      S_HOLD_POST = 3'd4
   } state_e;

   // Maps the pull settings in the cfg byte to the pad drive mode:
   //   strong up/down when pulls are off,
   //   resistive pull-up (010) or pull-down (011) otherwise.
   function automatic logic [2:0] drive_mode(input logic pull_en, input logic pull_up);
      logic [2:0] dm;
      if (!pull_en) begin
         dm = 3'b110;
      end else if (pull_up) begin
         dm = 3'b010;
      end else begin
         dm = 3'b011;
      end
      return dm;
   endfunction

   // Builds one pad's tech_cfg word.
   // Inputs:
   //   sh  : low three bits of the pad's shadow register
   //   hld : HLD_H_N
   //   en  : ENABLE_H, which also drives ENABLE_VDDIO
   // The input, VDDA, VSWITCH, IB_MODE and VTRIP controls stay at 0.
   function automatic logic [TECH_CFG_WIDTH-1:0] pad_word(input logic [2:0] sh,
                                                          input logic       hld,
                                                          input logic       en);
      logic [TECH_CFG_WIDTH-1:0] w;
      w        = '0;
      w[0]     = hld;
      w[1]     = en;
      w[5]     = en;
      w[8]     = sh[2];
      w[15:13] = drive_mode(sh[0], sh[1]);
      return w;
   endfunction

   state_e                      state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [PW-1:0]               tgt_q, tgt_d;
   logic [7:0]                  cfg_q, cfg_d;
   logic [7:0]                  shadow_q [N];
   logic [7:0]                  shadow_d [N];
   logic [N*TECH_CFG_WIDTH-1:0] tech_cfg_q, tech_cfg_d;
   logic                        req_ready_q, req_ready_d;
   logic                        busy_q, busy_d;
   logic                        pwr_good_q, pwr_good_d;
   logic                        cfg_done_q, cfg_done_d;
   logic                        cfg_err_q, cfg_err_d;
   logic                        pad_in_range;

   assign pad_in_range = ({1'b0, req_pad} < N_EXT);

   // Next-state logic: power-up timing, request acceptance, and the
   // two-phase hold sequence around each shadow update.
   always_comb begin
      // NOTE: every signal gets a default before the case statement. No path
      // can leave a signal unassigned, so no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      tgt_d      = tgt_q;
      cfg_d      = cfg_q;
      shadow_d   = shadow_q;
      cfg_done_d = 1'b0;
      cfg_err_d  = 1'b0;

      unique case (state_q)
         S_PWR_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_ENABLE;
               cnt_d   = HOLD_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_ENABLE: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_IDLE: begin
            // An out-of-range pad is accepted but only flags an error.
            // The controller stays in IDLE and keeps accepting requests.
            if (req_valid && req_ready_q) begin
               if (pad_in_range) begin
                  state_d = S_HOLD_PRE;
                  cnt_d   = HOLD_LOAD;
                  tgt_d   = req_pad;
                  cfg_d   = req_cfg;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end

         S_HOLD_PRE: begin
            // The new settings land in the shadow as the state moves to
            // HOLD_POST. Hold stays asserted on both sides of the change.
            if (cnt_q == '0) begin
               state_d = S_HOLD_POST;
               cnt_d   = HOLD_LOAD;
               for (int i = 0; i < N; i++) begin
                  if (tgt_q == PW'(i)) begin
                     shadow_d[i] = cfg_q;
                  end
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_HOLD_POST: begin
            if (cnt_q == '0) begin
               state_d    = S_IDLE;
               cfg_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = S_PWR_WAIT;
            cnt_d   = ENA_LOAD;
         end
      endcase
   end

   // Output decode from the next-state values. The output flops therefore
   // track the FSM with no extra cycle of delay.
   always_comb begin
      req_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d == S_HOLD_PRE) || (state_d == S_HOLD_POST);
      pwr_good_d  = (state_d == S_IDLE) || busy_d;
      tech_cfg_d  = '0;
      for (int i = 0; i < N; i++) begin
         tech_cfg_d[i*TECH_CFG_WIDTH +: TECH_CFG_WIDTH] =
            pad_word(shadow_d[i][2:0],
                     pwr_good_d && !(busy_d && (tgt_d == PW'(i))),
                     state_d != S_PWR_WAIT);
      end
   end

   // State, counter, request latch, shadows and registered outputs.
   // Synchronous reset restarts the full power sequence and drops any write
   // in flight.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned with non-blocking '<=' only.
      // Every flop then samples values from before the edge, whatever the
      // order of the statements.
      if (reset) begin
         state_q     <= S_PWR_WAIT;
         cnt_q       <= ENA_LOAD;
         tgt_q       <= '0;
         cfg_q       <= '0;
         // NOTE: the shadow array is reset on purpose. The pads must come
         // back from reset in the defined strong-drive mode, with no stale
         // pull or slew settings.
         for (int i = 0; i < N; i++) begin
            shadow_q[i] <= '0;
         end
         tech_cfg_q  <= {N{RESET_WORD}};
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         pwr_good_q  <= 1'b0;
         cfg_done_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tgt_q       <= tgt_d;
         cfg_q       <= cfg_d;
         shadow_q    <= shadow_d;
         tech_cfg_q  <= tech_cfg_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         pwr_good_q  <= pwr_good_d;
         cfg_done_q  <= cfg_done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign tech_cfg  = tech_cfg_q;
   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign pwr_good  = pwr_good_q;
   assign cfg_done  = cfg_done_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sky130_iocfg_seq.sv
// Testbench for sky130_iocfg_seq.
// The main instance (N=4, ENABLE_DLY=16, HOLD_DLY=4) is checked through a
// scoreboard: each entry gives a cycle number, an expected tech_cfg/status
// pattern and the mask of bits to compare.
// A second instance (N=3, short delays) covers the out-of-range pad case.

module tb_sky130_iocfg_seq;

   localparam int N  = 4;
   localparam int PW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [PW-1:0] req_pad;
   logic [7:0]    req_cfg;
   logic          cfg_done, cfg_err, busy, pwr_good;
   logic [63:0]   tech_cfg;
   logic [4:0]    status;

   logic          rst2, valid2, ready2, done2, err2, busy2, pg2;
   logic [1:0]    pad2;
   logic [7:0]    cfg2;
   logic [47:0]   tc2;
   logic [4:0]    st2;

   int total;
   int bad;
   int cyc;

   always #5 clk = ~clk;

   sky130_iocfg_seq #(.N(4), .TECH_CFG_WIDTH(16), .ENABLE_DLY(16), .HOLD_DLY(4)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_pad(req_pad), .req_cfg(req_cfg), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .busy(busy), .pwr_good(pwr_good), .tech_cfg(tech_cfg)
   );

   sky130_iocfg_seq #(.N(3), .TECH_CFG_WIDTH(16), .ENABLE_DLY(2), .HOLD_DLY(1)) dut3 (
      .clk(clk), .reset(rst2), .req_valid(valid2), .req_ready(ready2),
      .req_pad(pad2), .req_cfg(cfg2), .cfg_done(done2), .cfg_err(err2),
      .busy(busy2), .pwr_good(pg2), .tech_cfg(tc2)
   );

   // Status bits, in order: {req_ready, busy, pwr_good, cfg_done, cfg_err}.
   assign status = {req_ready, busy, pwr_good, cfg_done, cfg_err};
   assign st2    = {ready2, busy2, pg2, done2, err2};

   // Cycle 0 is the first cycle with reset low.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      int          cyc;
      logic [63:0] tc;
      logic [63:0] tcm;
      logic [4:0]  st;
      logic [4:0]  stm;
      string       name;
   } sb_t;

   sb_t sb[$];

   task automatic expect_at(input int c, input logic [63:0] tc, input logic [63:0] tcm,
                            input logic [4:0] st, input logic [4:0] stm, input string name);
      sb_t e;
      e.cyc  = c;
      e.tc   = tc;
      e.tcm  = tcm;
      e.st   = st;
      e.stm  = stm;
      e.name = name;
      sb.push_back(e);
   endtask

   // Compares every entry that is due this cycle. An entry whose cycle has
   // already passed is reported as missed.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check($sformatf("%s@%0d/tc", sb[i].name, sb[i].cyc), tech_cfg & sb[i].tcm, sb[i].tc & sb[i].tcm);
            check($sformatf("%s@%0d/st", sb[i].name, sb[i].cyc), 64'(status & sb[i].stm), 64'(sb[i].st & sb[i].stm));
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            check($sformatf("%s/missed", sb[i].name), 64'(cyc), 64'(sb[i].cyc));
            sb.delete(i);
         end
      end
   end

   // Reference model of the pad word, built from the field table.
   logic [7:0] sh_m [N];

   function automatic logic [15:0] word_m(input logic [7:0] sh, input logic hld, input logic en);
      logic [2:0] dm;
      case ({sh[1], sh[0]})
         2'b01:   dm = 3'b011;
         2'b11:   dm = 3'b010;
         default: dm = 3'b110;
      endcase
      return {dm, 4'b0000, sh[2], 2'b00, en, 3'b000, en, hld};
   endfunction

   // All pads in the run state. The pad at index hold_pad has HLD_H_N low;
   // pass -1 when no pad is held.
   function automatic logic [63:0] run_all(input int hold_pad);
      logic [63:0] v;
      v = '0;
      for (int p = 0; p < N; p++) v[p*16 +: 16] = word_m(sh_m[p], p != hold_pad, 1'b1);
      return v;
   endfunction

   localparam logic [63:0] ALL      = {64{1'b1}};
   localparam logic [63:0] NO_VDDIO = {4{16'hFFDF}};
   localparam logic [4:0]  ALLST    = 5'h1F;

   task automatic wait_cycle(input int c);
      int n;
      n = 0;
      while (cyc != c && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (cyc != c) check("wait_cycle", 64'(cyc), 64'(c));
   endtask

   typedef struct {
      logic [1:0]  pad;
      logic [7:0]  cfg;
      logic [15:0] final_word;
      bit          b2b;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      vecs[0] = '{pad: 2'd2, cfg: 8'h07, final_word: 16'h4123, b2b: 1'b0};
      vecs[1] = '{pad: 2'd1, cfg: 8'h01, final_word: 16'h6023, b2b: 1'b0};
      vecs[2] = '{pad: 2'd3, cfg: 8'h03, final_word: 16'h4023, b2b: 1'b1};
      vecs[3] = '{pad: 2'd1, cfg: 8'h01, final_word: 16'h6023, b2b: 1'b0};
      vecs[4] = '{pad: 2'd0, cfg: 8'h00, final_word: 16'hC023, b2b: 1'b0};

      total = 0;
      bad = 0;
      reset = 1'b1;
      req_valid = 1'b0;
      req_pad = '0;
      req_cfg = '0;
      rst2 = 1'b1;
      valid2 = 1'b0;
      pad2 = '0;
      cfg2 = '0;
      for (int p = 0; p < N; p++) sh_m[p] = '0;

      // Power-up after reset release.
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      expect_at(0,  {4{16'hC000}}, ALL,      5'b00000, ALLST, "rst_val");
      expect_at(5,  {4{16'hC000}}, ALL,      5'b00000, ALLST, "pwr_wait_held_req");
      expect_at(15, {4{16'hC000}}, ALL,      5'b00000, ALLST, "pwr_wait_end");
      expect_at(16, {4{16'hC002}}, NO_VDDIO, 5'b00000, ALLST, "enable_first");
      expect_at(19, {4{16'hC002}}, NO_VDDIO, 5'b00000, ALLST, "enable_last");
      expect_at(20, run_all(-1),   ALL,      5'b10100, ALLST, "pwr_good_rise");

      // A request held through power-up is accepted on the first IDLE cycle
      // (cycle 20).
      wait_cycle(2);
      req_valid = 1'b1;
      req_pad   = 2'd0;
      req_cfg   = 8'h04;
      expect_at(21, run_all(0), ALL, 5'b01100, ALLST, "early_pre_first");
      expect_at(24, run_all(0), ALL, 5'b01100, ALLST, "early_pre_last");
      sh_m[0] = 8'h04;
      expect_at(25, run_all(0),  ALL,  5'b01100, ALLST,    "early_post_first");
      expect_at(28, run_all(0),  ALL,  5'b01100, ALLST,    "early_post_last");
      expect_at(29, run_all(-1), ALL,  5'b10110, ALLST,    "early_done");
      expect_at(30, run_all(-1), ALL,  5'b10100, 5'b00010, "early_done_pulse");
      wait_cycle(21);
      req_valid = 1'b0;

      // Table-driven writes; a b2b entry is issued in the cycle cfg_done is high.
      t = 32;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) t = vecs[k].b2b ? t + 9 : t + 12;
         wait_cycle(t);
         req_valid = 1'b1;
         req_pad   = vecs[k].pad;
         req_cfg   = vecs[k].cfg;
         if (!vecs[k].b2b) expect_at(t, run_all(-1), ALL, 5'b10100, ALLST, $sformatf("w%0d_idle", k));
         expect_at(t + 1, run_all(int'(vecs[k].pad)), ALL, 5'b01100, ALLST, $sformatf("w%0d_pre_first", k));
         expect_at(t + 4, run_all(int'(vecs[k].pad)), ALL, 5'b01100, ALLST, $sformatf("w%0d_pre_last", k));
         sh_m[vecs[k].pad] = vecs[k].cfg;
         expect_at(t + 5, run_all(int'(vecs[k].pad)), ALL, 5'b01100, ALLST, $sformatf("w%0d_post_first", k));
         expect_at(t + 8, run_all(int'(vecs[k].pad)), ALL, 5'b01100, ALLST, $sformatf("w%0d_post_last", k));
         expect_at(t + 9, run_all(-1), ALL, 5'b10110, ALLST, $sformatf("w%0d_done", k));
         expect_at(t + 9, 64'(vecs[k].final_word) << (16 * vecs[k].pad),
                   64'(16'hFFFF) << (16 * vecs[k].pad), 5'b00010, 5'b00010, $sformatf("w%0d_final", k));
         expect_at(t + 10, run_all(-1), '0, 5'b00000, 5'b00010, $sformatf("w%0d_pulse", k));
         wait_cycle(t + 1);
         req_valid = 1'b0;
      end

      // Reset arrives at t+3 of a write. The write is discarded, the shadows
      // are cleared and power-up restarts.
      t = t + 12;
      wait_cycle(t);
      req_valid = 1'b1;
      req_pad   = 2'd2;
      req_cfg   = 8'h00;
      expect_at(t + 1, run_all(2), ALL, 5'b01100, ALLST, "rw_pre1");
      expect_at(t + 2, run_all(2), ALL, 5'b01100, ALLST, "rw_pre2");
      wait_cycle(t + 1);
      req_valid = 1'b0;
      wait_cycle(t + 3);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int p = 0; p < N; p++) sh_m[p] = '0;
      expect_at(0,  {4{16'hC000}}, ALL,      5'b00000, ALLST, "rr_val");
      expect_at(16, {4{16'hC002}}, NO_VDDIO, 5'b00000, ALLST, "rr_enable");
      expect_at(19, {4{16'hC002}}, NO_VDDIO, 5'b00000, ALLST, "rr_enable_last");
      expect_at(20, run_all(-1),   ALL,      5'b10100, ALLST, "rr_pwr_good");
      wait_cycle(22);

      // N=3 instance: short power-up, out-of-range pad, then one real write.
      @(posedge clk);
      #1 rst2 = 1'b0;
      @(negedge clk);
      check("n3_rst_tc", 64'(tc2), 64'({3{16'hC000}}));
      check("n3_rst_st", 64'(st2), 64'(5'b00000));
      @(negedge clk);
      check("n3_wait_st", 64'(st2), 64'(5'b00000));
      @(negedge clk);
      check("n3_enable_tc", 64'(tc2 & {3{16'hFFDF}}), 64'({3{16'hC002}}));
      check("n3_enable_st", 64'(st2), 64'(5'b00000));
      @(negedge clk);
      check("n3_run_tc", 64'(tc2), 64'({3{16'hC023}}));
      check("n3_run_st", 64'(st2), 64'(5'b10100));
      @(posedge clk);
      #1 valid2 = 1'b1;
      pad2 = 2'd3;
      cfg2 = 8'h07;
      @(posedge clk);
      #1 valid2 = 1'b0;
      @(negedge clk);
      check("n3_err_st", 64'(st2), 64'(5'b10101));
      check("n3_err_tc", 64'(tc2), 64'({3{16'hC023}}));
      @(negedge clk);
      check("n3_err_pulse", 64'(st2), 64'(5'b10100));
      @(posedge clk);
      #1 valid2 = 1'b1;
      pad2 = 2'd2;
      cfg2 = 8'h05;
      @(posedge clk);
      #1 valid2 = 1'b0;
      @(negedge clk);
      check("n3_pre_tc", 64'(tc2), 64'({16'hC022, 16'hC023, 16'hC023}));
      check("n3_pre_st", 64'(st2), 64'(5'b01100));
      @(negedge clk);
      check("n3_post_tc", 64'(tc2), 64'({16'h6122, 16'hC023, 16'hC023}));
      check("n3_post_st", 64'(st2), 64'(5'b01100));
      @(negedge clk);
      check("n3_done_tc", 64'(tc2), 64'({16'h6123, 16'hC023, 16'hC023}));
      check("n3_done_st", 64'(st2), 64'(5'b10110));
      @(negedge clk);
      check("n3_done_pulse", 64'(st2), 64'(5'b10100));

      check("sb_leftover", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sky130_iocfg_seq.md
# sky130_iocfg_seq

Power-on sequencer and run-time configuration controller for a bank of sky130 GPIO pad buffers. It produces the per-pad `tech_cfg` control vectors consumed by the `asic_iobuf` instances:

- Holds all pads hi-z until the I/O supply has settled, then enables them and releases the output hold.
- After power-up, accepts per-pad configuration writes over a valid/ready handshake.
- Applies each write glitch-free by holding the pad's outputs while the drive settings change.

## Interface
- `N`, 4, number of pads controlled (≥1)
- `TECH_CFG_WIDTH`, 16, width of each pad's tech_cfg vector (fixed at 16)
- `ENABLE_DLY`, 16, cycles ENABLE_H stays low after reset release (≥1)
- `HOLD_DLY`, 4, hold cycles before/after a settings change (≥1)
- `PW`, max(1,$clog2(N)), pad index width (derived)

- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  config write request
- `req_ready`  out  1  controller can accept a request
- `req_pad`  in  PW  target pad index
- `req_cfg`  in  8  cfg byte: [0] pull_enable, [1] pull_select (1=up), [2] slew limit, [7:3] stored, no effect
- `cfg_done`  out  1  one-cycle pulse when a write completes
- `cfg_err`  out  1  one-cycle pulse on out-of-range req_pad
- `busy`  out  1  write sequence in progress
- `pwr_good`  out  1  power-up sequence complete
- `tech_cfg`  out  N*16  pad i uses bits [16i+15:16i]

## Operation
- Per-pad tech_cfg fields:
  - [0] HLD_H_N
  - [1] ENABLE_H
  - [2] ENABLE_INP_H=0
  - [3] ENABLE_VDDA_H=0
  - [4] ENABLE_VSWITCH_H=0
  - [5] ENABLE_VDDIO
  - [6] IB_MODE_SEL=0
  - [7] VTRIP_SEL=0
  - [8] SLOW=shadow[2]
  - [12:9]=0
  - [15:13] DM
- DM mapping:
  - pull_enable=0 → 3'b110 (strong up/down)
  - pull_enable=1, pull_select=1 → 3'b010 (resistive pull-up)
  - pull_enable=1, pull_select=0 → 3'b011 (resistive pull-down)
- Each pad has an 8-bit shadow register, reset to 8'h00.
- Global FSM:
  - PWR_WAIT: ENABLE_H=0, HLD_H_N=0, ENABLE_VDDIO=0. Lasts ENABLE_DLY cycles.
  - ENABLE: ENABLE_H=1, ENABLE_VDDIO=1, HLD_H_N=0. Lasts HOLD_DLY cycles.
  - IDLE: all HLD_H_N=1, pwr_good=1, req_ready=1.
  - HOLD_PRE: target pad HLD_H_N=0, old settings. Lasts HOLD_DLY cycles.
  - HOLD_POST: shadow updated on entry, target HLD_H_N=0. Lasts HOLD_DLY cycles, then → IDLE with cfg_done pulse.
- Only the target pad's HLD_H_N drops during a write; other pads are unaffected.
- A write with a cfg equal to the current shadow still runs the full sequence.
- Out-of-range req_pad (≥N): the request is accepted in IDLE and cfg_err pulses the next cycle. No sequence runs, no state changes, and req_ready stays 1.
- A single down-counter of width $clog2(max(ENABLE_DLY,HOLD_DLY)+1) serves all timed states.
- Reset values:
  - every pad's tech_cfg = 16'hC000
  - req_ready=0, busy=0, pwr_good=0, cfg_done=0, cfg_err=0
  - all shadows 0, FSM in PWR_WAIT
- Reset asserted mid-write or mid-power-up: next edge restores the reset values and the full power sequence restarts. Any in-flight write is discarded.

## Timing
- Cycle 0 is the first cycle with reset low.
- ENABLE_H=1 from cycle ENABLE_DLY.
- HLD_H_N=1, pwr_good=1 and req_ready=1 from cycle ENABLE_DLY+HOLD_DLY.
- Run-state tech_cfg for a pad with shadow 0 is 16'hC023.
- Write accepted on an edge with req_valid&req_ready at cycle t:
  - t+1 .. t+2·HOLD_DLY: busy=1, req_ready=0, target HLD_H_N=0.
  - new SLOW/DM visible from t+HOLD_DLY+1.
  - t+2·HOLD_DLY+1: HLD_H_N=1, busy=0, req_ready=1, cfg_done=1 (single cycle).
- Back-to-back writes: the next can be accepted in the cycle cfg_done is high.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset release, ENABLE_DLY=16, HOLD_DLY=4 → pad0 tech_cfg 16'hC000 cycles 0–15, 16'hC002 cycles 16–19, 16'hC023 from cycle 20; pwr_good rises at cycle 20.
- Write pad2 cfg 8'h07 at t → pad2 HLD_H_N=0 t+1..t+8; tech_cfg 16'h4122 from t+5; 16'h4123 and cfg_done at t+9; pads 0,1,3 stay 16'hC023.
- Write pad1 cfg 8'h01 → DM=3'b011, final tech_cfg 16'h6023; the next request (pad3 cfg 8'h03) accepted the cycle cfg_done is high completes 9 cycles later with pad3 = 16'h4023.
- N=3, req_pad=3 → cfg_err pulse at t+1, busy stays 0, no tech_cfg change.
- Reset asserted at t+3 of a write → all pads 16'hC000 next cycle, shadow cleared, pwr_good returns after ENABLE_DLY+HOLD_DLY cycles.
- req_valid held during PWR_WAIT/ENABLE → not accepted until pwr_good; accepted on the first IDLE cycle.
